// File: rtl/motor_pkg.sv
// Shared definitions for the motor input conditioning stage.
`timescale 1ns/1ps
package motor_pkg;

  localparam int DEB_CYCLES_DEF = 16;
  localparam int CNT_W_DEF      = 5;

  // Channel indices into the packed raw/db vectors.
  localparam int NUM_CH = 3;
  localparam int CH_BTN = 0;
  localparam int CH_UP  = 1;
  localparam int CH_DN  = 2;

  typedef enum logic {
    DEB_STABLE = 1'b0,
    DEB_COUNT  = 1'b1
  } deb_state_e;

endpackage

// File: rtl/debounce_ch.sv
// One conditioning channel: 2-flop synchronizer followed by a symmetric
// counter debouncer. db only changes after DEB_CYCLES consecutive
// synchronized samples that disagree with it; any agreeing sample drops
// the count back to zero.
`timescale 1ns/1ps
module debounce_ch
  import motor_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic sync,
  output logic db
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             meta_q, sync_q;
  deb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             db_q, db_d;

  // Plain two-flop synchronizer, nothing between the stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= raw;
      sync_q <= meta_q;
    end
  end

  // Debounce FSM: count disagreeing samples, toggle db on the last one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    db_d    = db_q;
    case (state_q)
      DEB_STABLE: begin
        if (sync_q != db_q) begin
          state_d = DEB_COUNT;
          cnt_d   = CNT_ONE;
        end
      end
      DEB_COUNT: begin
        if (sync_q == db_q) begin
          state_d = DEB_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DEB_STABLE;
          cnt_d   = '0;
          db_d    = ~db_q;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = DEB_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DEB_STABLE;
      cnt_q   <= '0;
      db_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
    end
  end

  assign sync = sync_q;
  assign db   = db_q;

endmodule

// File: rtl/motor_input_cond.sv
// Input conditioning ahead of the motor FSM: debounced limit levels,
// a both-limits fault flag and a single-cycle activate pulse per press.
`timescale 1ns/1ps
module motor_input_cond
  import motor_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  input  logic up_limit_raw,
  input  logic dn_limit_raw,
  output logic activate,
  output logic up_limit,
  output logic dn_limit,
  output logic limit_fault
);

  logic [NUM_CH-1:0] raw_vec, sync_vec, db_vec;

  assign raw_vec = {dn_limit_raw, up_limit_raw, btn_raw};

  debounce_ch #(
    .DEB_CYCLES(DEB_CYCLES),
    .CNT_W     (CNT_W)
  ) u_ch [NUM_CH-1:0] (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (raw_vec),
    .sync (sync_vec),
    .db   (db_vec)
  );

  logic       btn_db, btn_sync, up_db, dn_db;
  logic       btn_prev_q, btn_prev_d;
  logic       armed_q, armed_d;
  logic       act_q, act_d;
  logic       fault_q, fault_d;
  // Fills with ones after reset; bit 1 marks that the synchronizer output
  // holds a real sample of the pin instead of its reset value.
  logic [1:0] sync_vld_q, sync_vld_d;
  logic       pulse;

  assign btn_db   = db_vec[CH_BTN];
  assign btn_sync = sync_vec[CH_BTN];
  assign up_db    = db_vec[CH_UP];
  assign dn_db    = db_vec[CH_DN];

  // Edge detect, arming and fault qualification of the button.
  always_comb begin
    btn_prev_d = btn_db;
    sync_vld_d = {sync_vld_q[0], 1'b1};
    fault_d    = up_db & dn_db;
    pulse      = btn_db & ~btn_prev_q & armed_q & ~fault_q;
    act_d      = pulse;
    armed_d    = armed_q;
    // Arm only on a genuinely observed release, so a button held through
    // reset cannot fire when it finishes re-debouncing high.
    if (pulse)
      armed_d = 1'b0;
    else if (!btn_db && !btn_sync && sync_vld_q[1])
      armed_d = 1'b1;
  end

  // Top-level registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_prev_q <= 1'b0;
      armed_q    <= 1'b0;
      act_q      <= 1'b0;
      fault_q    <= 1'b0;
      sync_vld_q <= '0;
    end else begin
      btn_prev_q <= btn_prev_d;
      armed_q    <= armed_d;
      act_q      <= act_d;
      fault_q    <= fault_d;
      sync_vld_q <= sync_vld_d;
    end
  end

  assign activate    = act_q;
  assign up_limit    = up_db;
  assign dn_limit    = dn_db;
  assign limit_fault = fault_q;

endmodule

// File: tb/tb_motor_input_cond.sv
// Directed bench for motor_input_cond with DEB_CYCLES=4.
`timescale 1ns/1ps
module tb_motor_input_cond;

  logic clk = 1'b0;
  logic rst_n, btn_raw, up_limit_raw, dn_limit_raw;
  logic activate, up_limit, dn_limit, limit_fault;

  int checks = 0;
  int errors = 0;

  motor_input_cond #(.DEB_CYCLES(4), .CNT_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_raw     (btn_raw),
    .up_limit_raw(up_limit_raw),
    .dn_limit_raw(dn_limit_raw),
    .activate    (activate),
    .up_limit    (up_limit),
    .dn_limit    (dn_limit),
    .limit_fault (limit_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic btn, up, dn;
    int   cyc;
    logic act, upl, dnl, flt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic btn, logic up, logic dn, int cyc,
                              logic act, logic upl, logic dnl, logic flt);
    vec_t v;
    v.btn = btn; v.up = up; v.dn = dn; v.cyc = cyc;
    v.act = act; v.upl = upl; v.dnl = dnl; v.flt = flt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b", nm, got, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic a, input logic u,
                         input logic d, input logic f);
    chk({nm, " activate"}, activate, a);
    chk({nm, " up_limit"}, up_limit, u);
    chk({nm, " dn_limit"}, dn_limit, d);
    chk({nm, " limit_fault"}, limit_fault, f);
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic apply(input vec_t v, input int idx);
    for (int c = 0; c < v.cyc; c++) begin
      btn_raw = v.btn; up_limit_raw = v.up; dn_limit_raw = v.dn;
      @(posedge clk); #1;
      chk_all($sformatf("vec%0d.%0d", idx, c), v.act, v.upl, v.dnl, v.flt);
      @(negedge clk);
    end
  endtask

  // Runs n cycles from a negedge and returns the number of activate pulses.
  task automatic count_pulses(input int n, output int p);
    p = 0;
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      if (activate === 1'b1) p++;
      @(negedge clk);
    end
  endtask

  initial begin
    int p;
    rst_n = 1'b0; btn_raw = 1'b0; up_limit_raw = 1'b0; dn_limit_raw = 1'b0;

    //            btn up dn cyc  act up dn flt
    tbl.push_back(mk(0, 0, 0, 4,  0, 0, 0, 0));  // idle, arms
    tbl.push_back(mk(1, 0, 0, 6,  0, 0, 0, 0));  // press, db rises on 6th edge
    tbl.push_back(mk(1, 0, 0, 1,  1, 0, 0, 0));  // single pulse
    tbl.push_back(mk(1, 0, 0, 4,  0, 0, 0, 0));  // held: no more pulses
    tbl.push_back(mk(0, 0, 0, 8,  0, 0, 0, 0));  // release
    tbl.push_back(mk(1, 0, 0, 3,  0, 0, 0, 0));  // bounce 3 high
    tbl.push_back(mk(0, 0, 0, 1,  0, 0, 0, 0));  //        1 low
    tbl.push_back(mk(1, 0, 0, 3,  0, 0, 0, 0));  //        3 high
    tbl.push_back(mk(0, 0, 0, 6,  0, 0, 0, 0));  //        low: never fires
    tbl.push_back(mk(0, 1, 0, 5,  0, 0, 0, 0));  // up held
    tbl.push_back(mk(0, 1, 0, 4,  0, 1, 0, 0));  // up rises on 6th edge
    tbl.push_back(mk(0, 0, 0, 5,  0, 1, 0, 0));  // up release
    tbl.push_back(mk(0, 0, 0, 3,  0, 0, 0, 0));  // falls on 6th edge
    tbl.push_back(mk(0, 0, 1, 2,  0, 0, 0, 0));  // 2-cycle dn glitch
    tbl.push_back(mk(0, 0, 0, 6,  0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 3,  0, 0, 0, 0));  // DEB-1 cycle glitch
    tbl.push_back(mk(0, 0, 0, 6,  0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 2,  0, 0, 0, 0));  // up first
    tbl.push_back(mk(0, 1, 1, 3,  0, 0, 0, 0));  // dn two cycles later
    tbl.push_back(mk(0, 1, 1, 2,  0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1,  0, 1, 1, 0));  // fault lags dn db by 1
    tbl.push_back(mk(1, 1, 1, 10, 0, 1, 1, 1));  // press during fault
    tbl.push_back(mk(1, 1, 0, 5,  0, 1, 1, 1));  // clear dn, btn held
    tbl.push_back(mk(1, 1, 0, 1,  0, 1, 0, 1));
    tbl.push_back(mk(1, 1, 0, 6,  0, 1, 0, 0));  // no deferred pulse
    tbl.push_back(mk(0, 1, 0, 8,  0, 1, 0, 0));  // release
    tbl.push_back(mk(1, 1, 0, 6,  0, 1, 0, 0));  // re-press
    tbl.push_back(mk(1, 1, 0, 1,  1, 1, 0, 0));
    tbl.push_back(mk(1, 1, 0, 4,  0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 5,  0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4,  0, 0, 0, 0));

    // Reset state.
    repeat (3) @(posedge clk);
    #1 chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) apply(tbl[i], i);

    // Reset mid-count on the up channel while dn_limit is high.
    dn_limit_raw = 1'b1;
    repeat (8) begin @(posedge clk); @(negedge clk); end
    #1 chk("pre-reset dn_limit", dn_limit, 1'b1);
    up_limit_raw = 1'b1;
    repeat (4) begin @(posedge clk); @(negedge clk); end   // up cnt == 2
    rst_n = 1'b0; dn_limit_raw = 1'b0;
    #1 chk_all("async reset", 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      chk($sformatf("redebounce up F%0d", k), up_limit, (k >= 6) ? 1'b1 : 1'b0);
      @(negedge clk);
    end

    // Ordinary press after reset gives one pulse.
    btn_raw = 1'b1;
    count_pulses(10, p);
    checks++;
    if (p != 1) begin errors++; $display("FAIL press after reset pulses %0d expected 1", p); end

    // Button held through reset.
    rst_n = 1'b0; up_limit_raw = 1'b0;
    #1 chk_all("reset held btn", 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    count_pulses(15, p);
    checks++;
    if (p != 0) begin errors++; $display("FAIL held through reset pulses %0d expected 0", p); end
    btn_raw = 1'b0;
    count_pulses(10, p);
    checks++;
    if (p != 0) begin errors++; $display("FAIL release pulses %0d expected 0", p); end
    btn_raw = 1'b1;
    count_pulses(12, p);
    checks++;
    if (p != 1) begin errors++; $display("FAIL re-press pulses %0d expected 1", p); end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
